nes_mem_arbiter: RTL and testbench

- Shares one port of the NES work-RAM (a synchronous RAM port with one-cycle read latency) between the 6502 core and the host Avalon-MM slave bus.
- The CPU owns the port by default.
- A pending host access is granted after a bounded wait; the CPU is stalled through `cpu_ready` while the host owns the port.
- One restore cycle re-presents the CPU address before the CPU resumes.

---
 rtl/nes_mem_arbiter.sv | 116 +++++++++++
 tb/tb_nes_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nes_mem_arbiter.sv
// Shares one synchronous work-RAM port between the 6502 core and an Avalon-MM host.
// The CPU owns the port by default. A host access takes one grant cycle, then one restore cycle.
module nes_mem_arbiter #(
  parameter int ADDR_W        = 11,
  parameter int HOST_WAIT_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [15:0]       address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_write,
  input  logic [7:0]        cpu_d_out,
  output logic [7:0]        cpu_d_in,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data_in,
  output logic              ram_we,
  input  logic [7:0]        ram_data_out
);

  typedef enum logic [1:0] {CPU_OWN, HOST_ACC, RESTORE} state_t;

  localparam logic [3:0] WAIT_MAX = 4'(HOST_WAIT_MAX);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       op_read, in_range_q;
  logic [7:0] readdata_q;
  logic       hreq, in_range;
  logic       cpu_addr_unused;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + 4'd1;
  endfunction

  assign hreq            = chipselect & (read | write);
  assign in_range        = (address >> ADDR_W) == 16'd0;
  assign waitrequest     = hreq & (state != HOST_ACC);
  assign cpu_d_in        = ram_data_out;
  assign cpu_addr_unused = ^cpu_addr[15:ADDR_W];

  // A CPU write cycle is never preempted; the grant slips while cpu_write is high.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CPU_OWN: begin
        cnt_nxt = hreq ? sat_inc(cnt) : 4'd0;
        if (hreq && (cnt == WAIT_MAX) && !cpu_write)
          state_nxt = HOST_ACC;
      end
      HOST_ACC: begin
        cnt_nxt   = 4'd0;
        state_nxt = RESTORE;
      end
      RESTORE: state_nxt = CPU_OWN;
      default: begin
        cnt_nxt   = 4'd0;
        state_nxt = CPU_OWN;
      end
    endcase
  end

  // RESTORE re-presents the CPU address so cpu_d_in is valid again when the CPU resumes.
  always_comb begin
    ram_addr      = cpu_addr[ADDR_W-1:0];
    ram_data_in   = cpu_d_out;
    ram_we        = cpu_write;
    cpu_ready     = 1'b1;
    readdatavalid = 1'b0;
    readdata      = readdata_q;
    case (state)
      HOST_ACC: begin
        ram_addr    = address[ADDR_W-1:0];
        ram_data_in = writedata;
        ram_we      = write & ~read & in_range;
        cpu_ready   = 1'b0;
      end
      RESTORE: begin
        ram_we        = 1'b0;
        cpu_ready     = 1'b0;
        readdatavalid = op_read;
        if (op_read)
          readdata = in_range_q ? ram_data_out : 8'hFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CPU_OWN;
      cnt        <= 4'd0;
      op_read    <= 1'b0;
      in_range_q <= 1'b0;
      readdata_q <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == HOST_ACC) begin
        op_read    <= read;
        in_range_q <= in_range;
      end
      if (state == RESTORE && op_read)
        readdata_q <= readdata;
    end
  end

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Directed bench for nes_mem_arbiter: instance a uses HOST_WAIT_MAX=2, instance b uses 0.
// Each instance drives its own behavioural work RAM with one-cycle read latency.
module tb_nes_mem_arbiter;

  logic        clk, reset;
  logic        chipselect, read, write;
  logic [15:0] address, cpu_addr;
  logic [7:0]  writedata, cpu_d_out;
  logic        cpu_write;

  logic [7:0]  readdata_a, cpu_d_in_a, ram_data_in_a, ram_q_a;
  logic        readdatavalid_a, waitrequest_a, cpu_ready_a, ram_we_a;
  logic [10:0] ram_addr_a;
  logic [7:0]  readdata_b, cpu_d_in_b, ram_data_in_b, ram_q_b;
  logic        readdatavalid_b, waitrequest_b, cpu_ready_b, ram_we_b;
  logic [10:0] ram_addr_b;

  logic [7:0]  mem_a [0:2047];
  logic [7:0]  mem_b [0:2047];

  int n_chk = 0;
  int n_bad = 0;

  nes_mem_arbiter #(.ADDR_W(11), .HOST_WAIT_MAX(2)) dut_a (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata_a),
    .readdatavalid(readdatavalid_a), .waitrequest(waitrequest_a),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_d_out(cpu_d_out),
    .cpu_d_in(cpu_d_in_a), .cpu_ready(cpu_ready_a), .ram_addr(ram_addr_a),
    .ram_data_in(ram_data_in_a), .ram_we(ram_we_a), .ram_data_out(ram_q_a)
  );

  nes_mem_arbiter #(.ADDR_W(11), .HOST_WAIT_MAX(0)) dut_b (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata_b),
    .readdatavalid(readdatavalid_b), .waitrequest(waitrequest_b),
    .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_d_out(cpu_d_out),
    .cpu_d_in(cpu_d_in_b), .cpu_ready(cpu_ready_b), .ram_addr(ram_addr_b),
    .ram_data_in(ram_data_in_b), .ram_we(ram_we_b), .ram_data_out(ram_q_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem_a[ram_addr_a] <= ram_data_in_a;
    ram_q_a <= mem_a[ram_addr_a];
    if (ram_we_b) mem_b[ram_addr_b] <= ram_data_in_b;
    ram_q_b <= mem_b[ram_addr_b];
  end

  task automatic chk(input string tag, input int cyc, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s c%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic host_idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
  endtask

  task automatic set_cpu_t4(input int c);
    cpu_write = (c >= 2 && c <= 5);
    cpu_addr  = cpu_write ? 16'h0030 : 16'h0010;
    cpu_d_out = 8'h5A;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = 8'(i) ^ 8'h3C;
      mem_b[i] = 8'(i) ^ 8'h3C;
    end
    clk = 1'b0; reset = 1'b1;
    host_idle();
    address = 16'h0000; writedata = 8'h00;
    cpu_addr = 16'h0010; cpu_write = 1'b0; cpu_d_out = 8'h00;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    repeat (2) next_cycle();

    // asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("rst rdy", 0, 16'(cpu_ready_a), 16'h1);
    chk("rst rdv", 0, 16'(readdatavalid_a), 16'h0);
    chk("rst rdata", 0, 16'(readdata_a), 16'h00);
    chk("rst addr", 0, 16'(ram_addr_a), 16'h0010);
    chk("rst wait", 0, 16'(waitrequest_a), 16'h0);
    chk("rst we", 0, 16'(ram_we_a), 16'h0);
    next_cycle();
    reset = 1'b0;
    repeat (2) next_cycle();

    // host write A5 -> 0x0123
    chipselect = 1'b1; write = 1'b1; address = 16'h0123; writedata = 8'hA5;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("wr we", c, 16'(ram_we_a), 16'(c == 3));
      chk("wr rdy", c, 16'(cpu_ready_a), 16'(!(c == 3 || c == 4)));
      chk("wr wait", c, 16'(waitrequest_a), 16'(c < 3));
      if (c == 3) chk("wr addr", c, 16'(ram_addr_a), 16'h0123);
      next_cycle();
      if (c == 3) host_idle();
    end
    repeat (3) next_cycle();

    // host read 0x0123
    chipselect = 1'b1; read = 1'b1; address = 16'h0123;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rd rdv", c, 16'(readdatavalid_a), 16'(c == 4));
      if (c >= 4) chk("rd data", c, 16'(readdata_a), 16'h00A5);
      if (c == 0 || c == 5) chk("rd cpu_d_in", c, 16'(cpu_d_in_a), 16'h002C);
      next_cycle();
      if (c == 3) host_idle();
    end
    repeat (3) next_cycle();

    // CPU writes on cycles 2-5 block a pending host read
    chipselect = 1'b1; read = 1'b1; address = 16'h0123;
    set_cpu_t4(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("cw rdy", c, 16'(cpu_ready_a), 16'(!(c == 7 || c == 8)));
      chk("cw wait", c, 16'(waitrequest_a), 16'(c < 7));
      chk("cw we", c, 16'(ram_we_a), 16'(c >= 2 && c <= 5));
      chk("cw rdv", c, 16'(readdatavalid_a), 16'(c == 8));
      if (c == 8) chk("cw data", c, 16'(readdata_a), 16'h00A5);
      next_cycle();
      if (c == 7) host_idle();
      set_cpu_t4(c + 1);
    end
    repeat (3) next_cycle();

    // out-of-range write is dropped but completes
    chipselect = 1'b1; write = 1'b1; address = 16'h0900; writedata = 8'h55;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("oor we", c, 16'(ram_we_a), 16'h0);
      chk("oor rdy", c, 16'(cpu_ready_a), 16'(!(c == 3 || c == 4)));
      chk("oor wait", c, 16'(waitrequest_a), 16'(c < 3));
      next_cycle();
      if (c == 3) host_idle();
    end
    repeat (3) next_cycle();

    // out-of-range read returns FF
    chipselect = 1'b1; read = 1'b1; address = 16'hC000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("oor rdv", c, 16'(readdatavalid_a), 16'(c == 4));
      if (c == 0) chk("oor hold", c, 16'(readdata_a), 16'h00A5);
      if (c == 4) chk("oor data", c, 16'(readdata_a), 16'h00FF);
      next_cycle();
      if (c == 3) host_idle();
    end
    cpu_addr = 16'h0042;
    repeat (3) next_cycle();

    // saturating host reads on the HOST_WAIT_MAX=0 instance
    chipselect = 1'b1; read = 1'b1; address = 16'h0123;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("sat rdy", c, 16'(cpu_ready_b), 16'(c % 3 == 0));
      chk("sat rdv", c, 16'(readdatavalid_b), 16'(c % 3 == 2));
      if (c % 3 == 2) chk("sat data", c, 16'(readdata_b), 16'h00A5);
      if (c % 3 == 0) chk("sat cpu_d_in", c, 16'(cpu_d_in_b), 16'h007E);
      next_cycle();
    end
    host_idle();
    repeat (4) next_cycle();
    cpu_addr = 16'h0010;
    next_cycle();

    // reset during RESTORE of a host read that the host keeps holding
    chipselect = 1'b1; read = 1'b1; address = 16'h0123;
    for (int c = 0; c < 11; c++) begin
      if (c == 4) begin
        #2 reset = 1'b1;
        #1;
        chk("mid rst rdv", c, 16'(readdatavalid_a), 16'h0);
        chk("mid rst rdy", c, 16'(cpu_ready_a), 16'h1);
      end
      @(negedge clk);
      chk("mid rdv", c, 16'(readdatavalid_a), 16'(c == 9));
      chk("mid rdy", c, 16'(cpu_ready_a), 16'(!(c == 3 || c == 8 || c == 9)));
      chk("mid wait", c, 16'(waitrequest_a), 16'(!(c == 3 || c >= 8)));
      if (c == 5) chk("mid rdata clr", c, 16'(readdata_a), 16'h0000);
      if (c == 9) chk("mid data", c, 16'(readdata_a), 16'h00A5);
      next_cycle();
      if (c == 4) reset = 1'b0;
      if (c == 8) host_idle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
